// File: rtl/conff_pkg.sv
// Shared constants for the conditional-branch flag unit: condition codes and
// the position of the C2 condition field inside the instruction register.
package conff_pkg;

   localparam logic [1:0] BR_ZR = 2'b00;
   localparam logic [1:0] BR_NZ = 2'b01;
   localparam logic [1:0] BR_PL = 2'b10;
   localparam logic [1:0] BR_MI = 2'b11;

   localparam int C2_HI = 20;
   localparam int C2_LO = 19;

endpackage

// File: rtl/conff_dec.sv
// 2-to-4 one-hot decoder for the branch condition code.
// Bit order: 0 = brzr, 1 = brnz, 2 = brpl, 3 = brmi.
module conff_dec
   import conff_pkg::*;
(
   input  logic [1:0] cond,
   output logic [3:0] onehot
);

   always_comb begin
      onehot = 4'b0000;
      case (cond)
         BR_ZR:   onehot = 4'b0001;
         BR_NZ:   onehot = 4'b0010;
         BR_PL:   onehot = 4'b0100;
         BR_MI:   onehot = 4'b1000;
         default: onehot = 4'b0000;
      endcase
   end

endmodule

// File: rtl/conff_branch_unit.sv
// Conditional-branch flag unit: evaluates the IR condition against the bus and
// latches the result into CON on ConIn. Optional debug port via CONFF_COND_OUT_EN.
module conff_branch_unit
   import conff_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             clear,
   input  logic             ConIn,
   input  logic [WIDTH-1:0] IR,
   input  logic [WIDTH-1:0] BusMuxIn,
`ifdef CONFF_COND_OUT_EN
   output logic [3:0]       cond_onehot,
`endif
   output logic             branch
);

   logic [1:0] cond;
   logic [3:0] dec;
   logic       zero;
   logic       neg;
   logic       con_d;
   logic       con_q;
   logic       unused_ir;

   assign cond = IR[C2_HI:C2_LO];

   // Only the C2 field matters; the remaining IR bits are deliberately dropped.
   assign unused_ir = ^{IR[WIDTH-1:C2_HI+1], IR[C2_LO-1:0]};

   conff_dec u_dec (
      .cond   (cond),
      .onehot (dec)
   );

`ifdef CONFF_COND_OUT_EN
   assign cond_onehot = dec;
`endif

   assign zero  = ~|BusMuxIn;
   assign neg   = BusMuxIn[WIDTH-1];

   // brpl passes on zero: zero counts as positive.
   assign con_d = (dec[0] & zero) | (dec[1] & ~zero) |
                  (dec[2] & ~neg) | (dec[3] & neg);

   always_ff @(posedge Clock or posedge clear) begin
      if (clear)
         con_q <= 1'b0;
      else if (ConIn)
         con_q <= con_d;
   end

   assign branch = con_q;

endmodule

// File: tb/tb_conff_branch_unit.sv
// Directed self-checking bench for conff_branch_unit with an expected-value queue.
// The cond_onehot checks are compiled only when CONFF_COND_OUT_EN is defined.
module tb_conff_branch_unit;

   logic        Clock = 1'b0;
   logic        clear;
   logic        ConIn;
   logic [31:0] IR;
   logic [31:0] BusMuxIn;
   logic        branch;
`ifdef CONFF_COND_OUT_EN
   logic [3:0]  cond_onehot;
`endif

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];

   conff_branch_unit #(.WIDTH(32)) dut (
      .Clock       (Clock),
      .clear       (clear),
      .ConIn       (ConIn),
      .IR          (IR),
      .BusMuxIn    (BusMuxIn),
`ifdef CONFF_COND_OUT_EN
      .cond_onehot (cond_onehot),
`endif
      .branch      (branch)
   );

   always #5 Clock = ~Clock;

   function automatic logic [31:0] mk_ir(input logic [1:0] c);
      logic [31:0] v;
      v = 32'h0;
      v[20:19] = c;
      return v;
   endfunction

   task automatic check_pop(input string tag);
      logic e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %b, expected queue empty", tag, branch);
      end else begin
         e = exp_q.pop_front();
         assert (branch === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, branch, e);
         end
      end
   endtask

   // Drive one ConIn step at a negedge, check branch at the following negedge.
   task automatic load(input logic [31:0] ir, input logic [31:0] bus,
                       input logic e, input string tag);
      @(negedge Clock);
      IR = ir; BusMuxIn = bus; ConIn = 1'b1;
      exp_q.push_back(e);
      @(negedge Clock);
      ConIn = 1'b0;
      check_pop(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 1'b1; ConIn = 1'b1; IR = mk_ir(2'b00); BusMuxIn = 32'h0;
      #1;
      exp_q.push_back(1'b0); check_pop("reset_immediate");
      repeat (2) begin
         @(negedge Clock);
         exp_q.push_back(1'b0); check_pop("reset_hold_clear_wins");
      end
      clear = 1'b0;
      exp_q.push_back(1'b0); check_pop("reset_release_no_edge");
      @(negedge Clock);
      exp_q.push_back(1'b1); check_pop("reset_first_load");
      ConIn = 1'b0;

      load(mk_ir(2'b00), 32'h0000_0000, 1'b1, "brzr_zero");
      load(mk_ir(2'b00), 32'h0000_0001, 1'b0, "brzr_one");
      load(mk_ir(2'b00), 32'h8000_0000, 1'b0, "brzr_msb");
      load(mk_ir(2'b01), 32'h0000_0001, 1'b1, "brnz_one");
      load(mk_ir(2'b01), 32'h0000_0000, 1'b0, "brnz_zero");
      load(mk_ir(2'b10), 32'h7FFF_FFFF, 1'b1, "brpl_maxpos");
      load(mk_ir(2'b10), 32'h8000_0000, 1'b0, "brpl_minneg");
      load(mk_ir(2'b10), 32'h0000_0000, 1'b1, "brpl_zero");
      load(mk_ir(2'b11), 32'hFFFF_FFFF, 1'b1, "brmi_neg1");
      load(mk_ir(2'b11), 32'h0000_0005, 1'b0, "brmi_pos");
      load(mk_ir(2'b11), 32'h0000_0000, 1'b0, "brmi_zero");

      // Hold: latch 1 then present failing conditions with ConIn low.
      load(mk_ir(2'b00), 32'h0, 1'b1, "hold_setup");
      for (int i = 0; i < 5; i++) begin
         IR = mk_ir(2'(i % 2)) ^ 32'h0000_0000;
         BusMuxIn = (i % 2 == 0) ? 32'h0000_0003 : 32'h0;
         if (i % 2 == 1) IR = mk_ir(2'b01);
         exp_q.push_back(1'b1);
         @(negedge Clock);
         check_pop("hold_conin_low");
      end

      load(32'h0000_0000, 32'h1, 1'b0, "field_iso_setup");
      load(32'hFFE7_FFFF, 32'h0, 1'b1, "field_iso_brzr");

      // Consecutive ConIn edges reload with the current d.
      @(negedge Clock);
      IR = mk_ir(2'b01); BusMuxIn = 32'h0000_0100; ConIn = 1'b1;
      exp_q.push_back(1'b1);
      @(negedge Clock);
      check_pop("consec_first");
      BusMuxIn = 32'h0;
      exp_q.push_back(1'b0);
      @(negedge Clock);
      check_pop("consec_second");
      BusMuxIn = 32'h0000_0100;
      @(negedge Clock);
      ConIn = 1'b0;
      exp_q.push_back(1'b1); check_pop("consec_third");

      // Asynchronous clear away from any edge.
      #2 clear = 1'b1;
      #1 exp_q.push_back(1'b0); check_pop("clear_async");
      clear = 1'b0;
      @(negedge Clock);
      exp_q.push_back(1'b0); check_pop("clear_stays_low");
      load(mk_ir(2'b11), 32'h8000_0001, 1'b1, "post_clear_load");

`ifdef CONFF_COND_OUT_EN
      for (int c = 0; c < 4; c++) begin
         logic [3:0] e4;
         e4 = 4'b0001 << c;
         IR = mk_ir(2'(c));
         #1;
         checks++;
         assert (cond_onehot === e4) else begin
            errors++;
            $error("FAIL cond_onehot_%0d: observed %b expected %b", c, cond_onehot, e4);
         end
      end
`endif

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL queue_drained: observed %0d entries expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
